// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the UART instruction-memory boot loader.
package boot_pkg;
    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERROR} loader_state_t;
    localparam logic [7:0] SYNC_BYTE      = 8'hA5;
    localparam int         BYTES_PER_WORD = 4;
endpackage

// File: rtl/imem_boot_loader_if.sv
// i_mem write-port bundle: the loader drives it (master), i_mem consumes it (slave).
interface imem_boot_loader_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                  mem_writeEnable;
    logic [ADDR_WIDTH-1:0] mem_writeAddress;
    logic [DATA_WIDTH-1:0] mem_writeData;

    modport master (output mem_writeEnable, output mem_writeAddress, output mem_writeData);
    modport slave  (input  mem_writeEnable, input  mem_writeAddress, input  mem_writeData);
endinterface

// File: rtl/imem_boot_loader_uart_rx.sv
// 8N1 UART byte receiver: 2-flop sync, start confirmed at half bit, mid-bit sampling.
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       sh_q, sh_d;
    logic             valid_q, valid_d, ferr_q, ferr_d;
    logic             rx_s1_q, rx_s2_q, rx_prev_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            sh_q      <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            sh_q      <= sh_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        sh_d    = sh_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (rx_prev_q && !rx_s2_q) state_d = RX_START;
            end
            RX_START: if (cnt_q == HALF) begin
                // A glitch that is high again at half bit is not a start bit
                cnt_d   = '0;
                bit_d   = '0;
                state_d = rx_s2_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (cnt_q == FULL) begin
                cnt_d = '0;
                sh_d  = {rx_s2_q, sh_q[7:1]};
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = RX_STOP;
            end
            RX_STOP: if (cnt_q == FULL) begin
                valid_d = rx_s2_q;
                ferr_d  = !rx_s2_q;
                state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_valid = valid_q;
    assign byte_data  = sh_q;
    assign frame_err  = ferr_q;
endmodule

// File: rtl/imem_boot_loader.sv
// Frame parser that writes a UART-delivered image into i_mem and releases the core
// only after the XOR checksum over the data bytes matches.
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 12,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rx,
    imem_boot_loader_if.master    mem,
    output logic                  cpu_reset,
    output logic                  load_done,
    output logic                  load_error,
    output logic [ADDR_WIDTH:0]   words_written
);
    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;
    localparam logic [1:0]  LAST_LANE = 2'(BYTES_PER_WORD - 1);

    logic       byte_valid, frame_err;
    logic [7:0] byte_data;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clock      (clock),
        .reset      (reset),
        .rx         (rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    loader_state_t         state_q, state_d;
    logic [15:0]           len_q, len_d, len_new;
    logic [1:0]            lane_q, lane_d;
    logic [DATA_WIDTH-1:0] word_q, word_d, wdata_q, wdata_d;
    logic [7:0]            csum_q, csum_d;
    logic [ADDR_WIDTH:0]   idx_q, idx_d, words_q, words_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic                  we_q, we_d;

    assign len_new = {byte_data, len_q[7:0]};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            lane_q  <= '0;
            word_q  <= '0;
            csum_q  <= '0;
            idx_q   <= '0;
            words_q <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            lane_q  <= lane_d;
            word_q  <= word_d;
            csum_q  <= csum_d;
            idx_q   <= idx_d;
            words_q <= words_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        lane_d  = lane_q;
        word_d  = word_q;
        csum_d  = csum_q;
        idx_d   = idx_q;
        words_d = words_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (frame_err && state_q != DONE) begin
            state_d = ERROR;
        end else if (byte_valid) begin
            case (state_q)
                IDLE, ERROR: if (byte_data == SYNC_BYTE) begin
                    state_d = LEN_LO;
                    words_d = '0;
                end
                LEN_LO: begin
                    len_d   = {8'h00, byte_data};
                    state_d = LEN_HI;
                end
                LEN_HI: begin
                    len_d  = len_new;
                    idx_d  = '0;
                    csum_d = '0;
                    lane_d = '0;
                    state_d = (len_new == 16'd0 || {1'b0, len_new} > MAX_WORDS) ? ERROR : DATA;
                end
                DATA: begin
                    // Little-endian: first byte shifts down to bits [7:0] after four bytes
                    word_d = {byte_data, word_q[DATA_WIDTH-1:8]};
                    csum_d = csum_q ^ byte_data;
                    lane_d = lane_q + 2'd1;
                    if (lane_q == LAST_LANE) begin
                        we_d    = 1'b1;
                        waddr_d = idx_q[ADDR_WIDTH-1:0];
                        wdata_d = word_d;
                        words_d = words_q + 1'b1;
                        idx_d   = idx_q + 1'b1;
                        if ((17'(idx_q) + 17'd1) == {1'b0, len_q}) state_d = CSUM;
                    end
                end
                CSUM: state_d = (byte_data == csum_q) ? DONE : ERROR;
                default: ;
            endcase
        end
    end

    assign mem.mem_writeEnable  = we_q;
    assign mem.mem_writeAddress = waddr_q;
    assign mem.mem_writeData    = wdata_q;
    assign cpu_reset     = (state_q != DONE);
    assign load_done     = (state_q == DONE);
    assign load_error    = (state_q == ERROR);
    assign words_written = words_q;
endmodule
